// File: rtl/usb_rx_pkg.sv
// Shared USB full-speed receive constants and the bit-timer state encoding.
// Decoder and RCU import the same timing constants so they stay consistent.
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT = 8;
    localparam int USB_STUFF_LIMIT  = 6;
    localparam int USB_SAMPLE_PHASE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        STUFF = 2'd2
    } timer_state_t;

endpackage

// File: rtl/usb_rx_bit_timer_if.sv
// Bit-timer strobes between edge detect/NRZI decoder, the timer and the RX shift register.
// master drives line-side inputs and observes the timing pulses; slave is the timer.
interface usb_rx_bit_timer_if;

    logic rcving;
    logic d_edge;
    logic d_orig;
    logic shift_enable;
    logic data_shift;
    logic byte_received;
    logic stuff_err;

    modport master (
        output rcving, d_edge, d_orig,
        input  shift_enable, data_shift, byte_received, stuff_err
    );

    modport slave (
        input  rcving, d_edge, d_orig,
        output shift_enable, data_shift, byte_received, stuff_err
    );

endinterface

// File: rtl/usb_phase_counter.sv
// Wrapping phase counter: counts 0..ROLLOVER, synchronous clear has priority over enable.
// Zero latency on count_o (registered value); no backpressure.
module usb_phase_counter #(
    parameter int ROLLOVER = 7,
    parameter int W        = 3
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] ROLL_VAL = W'(ROLLOVER);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == ROLL_VAL) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/usb_rx_bit_timer.sv
// USB FS RX bit timer: realigns an oversampled phase on every edge, strobes one shift per bit,
// drops stuffed bits. shift/data strobes are combinational; byte/stuff_err one cycle later; no backpressure.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = USB_SAMPLE_PHASE,
    parameter int STUFF_LIMIT  = USB_STUFF_LIMIT
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_rx_bit_timer_if.slave   bus
);

    localparam int PH_W   = $clog2(CLKS_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    localparam logic [PH_W-1:0]   SAMPLE_VAL = PH_W'(SAMPLE_PHASE);
    localparam logic [ONES_W-1:0] ONES_LAST  = ONES_W'(STUFF_LIMIT - 1);

    timer_state_t       state_q;
    timer_state_t       state_d;
    logic [PH_W-1:0]    phase;
    logic [ONES_W-1:0]  ones_q;
    logic [ONES_W-1:0]  ones_d;
    logic [2:0]         bit_q;
    logic [2:0]         bit_d;
    logic               byte_q;
    logic               byte_d;
    logic               err_q;
    logic               err_d;

    logic               active;
    logic               sample;
    logic               payload;
    logic               stuff_hit;

    assign active = (state_q != IDLE);

    // An edge restarts the bit cell; sampling at SAMPLE_PHASE lands mid-bit.
    usb_phase_counter #(
        .ROLLOVER (CLKS_PER_BIT - 1),
        .W        (PH_W)
    ) u_phase (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (!active || bus.d_edge),
        .en_i    (active),
        .count_o (phase)
    );

    assign sample    = active && (phase == SAMPLE_VAL);
    assign payload   = sample && (state_q == COUNT);
    assign stuff_hit = payload && bus.d_orig && (ones_q == ONES_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.rcving) state_d = COUNT;
            COUNT:   if (stuff_hit)  state_d = STUFF;
            STUFF:   if (sample)     state_d = COUNT;
            default: state_d = IDLE;
        endcase
        if (!bus.rcving) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        byte_d = 1'b0;
        err_d  = 1'b0;
        if (payload && (bit_q == 3'd7)) begin
            byte_d = 1'b1;
        end
        // The stuffed slot must be a 0; the bit is discarded either way.
        if (sample && (state_q == STUFF) && bus.d_orig) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        ones_d = ones_q;
        bit_d  = bit_q;
        if (!active) begin
            ones_d = '0;
            bit_d  = '0;
        end else if (payload) begin
            bit_d = bit_q + 3'd1;
            if (!bus.d_orig || stuff_hit) begin
                ones_d = '0;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_q <= '0;
            bit_q  <= '0;
            byte_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ones_q <= ones_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            err_q  <= err_d;
        end
    end

    assign bus.shift_enable  = sample;
    assign bus.data_shift    = payload;
    assign bus.byte_received = byte_q;
    assign bus.stuff_err     = err_q;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Scoreboard bench for usb_rx_bit_timer: expected output events are queued as packets are driven.
// Every cycle with any nonzero output pops and compares {cycle, outputs}.
module tb_usb_rx_bit_timer;

    localparam int STUFF_LIMIT = 6;

    logic clk;
    logic n_rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;

    logic [31:0] exp_q[$];

    usb_rx_bit_timer_if bus ();

    usb_rx_bit_timer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Outputs packed {shift_enable, data_shift, byte_received, stuff_err}.
    task automatic push(input int t, input logic [3:0] o);
        exp_q.push_back({t[27:0], o});
    endtask

    task automatic wait_cyc(input int tt);
        while (cyc < tt) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] o;
        o = {bus.shift_enable, bus.data_shift, bus.byte_received, bus.stuff_err};
        if (o != 4'b0000) begin
            if (exp_q.size() == 0) chk("unexpected", {cyc[27:0], o}, 32'h0);
            else                   chk("evt", {cyc[27:0], o}, exp_q.pop_front());
        end
    end

    // bits[i] is the i-th decoded bit on the line, stuffed slots included.
    // edge_after >= 0 injects a d_edge at phase 6 following that bit's sample.
    task automatic run_packet(input logic [15:0] bits, input int n, input int edge_after);
        int   t;
        int   t_last;
        int   ones;
        int   bitc;
        logic stuff;
        @(posedge clk);
        #1;
        t = cyc + 4;
        t_last = t;
        ones = 0;
        bitc = 0;
        stuff = 1'b0;
        bus.rcving = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (stuff) begin
                push(t, 4'b1000);
                if (bits[i]) push(t + 1, 4'b0001);
                stuff = 1'b0;
            end else begin
                push(t, 4'b1100);
                bitc++;
                if (bitc == 8) begin
                    push(t + 1, 4'b0010);
                    bitc = 0;
                end
                if (bits[i]) ones++;
                else         ones = 0;
                if (ones == STUFF_LIMIT) begin
                    ones = 0;
                    stuff = 1'b1;
                end
            end
            wait_cyc(t);
            bus.d_orig = bits[i];
            t_last = t;
            if (i == edge_after) begin
                wait_cyc(t + 3);
                bus.d_edge = 1'b1;
                wait_cyc(t + 4);
                bus.d_edge = 1'b0;
                t = t + 7;
            end else begin
                t = t + 8;
            end
        end
        wait_cyc(t_last + 2);
        bus.rcving = 1'b0;
        bus.d_orig = 1'b0;
        wait_cyc(t_last + 12);
    endtask

    initial begin
        int s;
        int r;
        n_rst      = 1'b0;
        bus.rcving = 1'b0;
        bus.d_edge = 1'b0;
        bus.d_orig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {28'h0, bus.shift_enable, bus.data_shift, bus.byte_received, bus.stuff_err}, 32'h0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        run_packet(16'h0000, 8, -1);   // free-run, one byte of zeros
        run_packet(16'h02B5, 10, 2);   // drift: edge at phase 6 after third bit
        run_packet(16'h003F, 9, -1);   // six 1s, stuffed 0, two more payload bits
        run_packet(16'h00FF, 9, -1);   // six 1s, stuffed slot carries a 1
        run_packet(16'h0015, 5, -1);   // aborted after five payload bits
        run_packet(16'h00A6, 8, -1);   // fresh packet needs a full eight bits
        run_packet(16'hC3A5, 16, -1);  // two bytes back to back

        // Async reset mid-bit at phase 5 while rcving stays high.
        @(posedge clk);
        #1;
        s = cyc;
        bus.rcving = 1'b1;
        push(s + 4, 4'b1100);
        wait_cyc(s + 6);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_outs", {28'h0, bus.shift_enable, bus.data_shift, bus.byte_received, bus.stuff_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        r = cyc;
        push(r + 4, 4'b1100);
        wait_cyc(r + 6);
        bus.rcving = 1'b0;
        wait_cyc(r + 20);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
